// File: rtl/nav_command_arbiter.sv
// Navigation button front end: synchronize, debounce, auto-repeat,
// then offer one command at a time over a valid/ready handshake.
module nav_command_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 20,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] btn,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic       busy
);

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] RD_LOAD = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] RP_LOAD = 24'(REPEAT_PERIOD - 1);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  sync_a, sync_b;
    logic [4:0]  deb, deb_q;
    logic [4:0]  pending, pend_nxt;
    logic [4:0]  press, fire, clr;
    logic [15:0] db_cnt [5];
    logic [23:0] rp_cnt [5];
    logic [2:0]  rr, rr_nxt, code_nxt, sel;
    logic [3:0]  idx;
    logic        found;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
            deb    <= '0;
            deb_q  <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
                rp_cnt[i] <= '0;
            end
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            deb_q  <= deb;
            for (int i = 0; i < 5; i++) begin
                if (sync_b[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    deb[i]    <= sync_b[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end

                // Down-counter to the next repeat; reloads on each fire.
                if (!deb[i]) begin
                    rp_cnt[i] <= '0;
                end else if (press[i]) begin
                    rp_cnt[i] <= RD_LOAD;
                end else if (rp_cnt[i] == 24'd0) begin
                    rp_cnt[i] <= RP_LOAD;
                end else begin
                    rp_cnt[i] <= rp_cnt[i] - 24'd1;
                end
            end
        end
    end

    always_comb begin
        press = '0;
        fire  = '0;
        for (int i = 0; i < 5; i++) begin
            press[i] = deb[i] & ~deb_q[i];
            fire[i]  = deb[i] & deb_q[i] & (rp_cnt[i] == 24'd0);
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = cmd_code;
        rr_nxt    = rr;
        clr       = '0;
        found     = 1'b0;
        sel       = '0;
        idx       = '0;
        for (int i = 0; i < 5; i++) begin
            idx = 4'(rr) + 4'(i);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!found && pending[idx[2:0]]) begin
                found = 1'b1;
                sel   = idx[2:0];
            end
        end
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = OFFER;
                    code_nxt  = sel;
                end
            end
            OFFER: begin
                if (cmd_ready) begin
                    clr[cmd_code] = 1'b1;
                    rr_nxt    = (cmd_code == 3'd4) ? 3'd0 : cmd_code + 3'd1;
                    state_nxt = IDLE;
                end
            end
        endcase
        // A new request on the clearing edge wins over the clear.
        pend_nxt = (pending & ~clr) | press | fire;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= '0;
            rr       <= '0;
            cmd_code <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pend_nxt;
            rr       <= rr_nxt;
            cmd_code <= code_nxt;
            busy     <= (|pend_nxt) | (state_nxt == OFFER);
        end
    end

    assign cmd_valid = (state == OFFER);

endmodule

// File: tb/tb_nav_command_arbiter.sv
// Directed bench for nav_command_arbiter with default parameters.
// Edge numbers count rising edges after the input change.
module tb_nav_command_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] btn;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       busy;

    int errors = 0;
    int checks = 0;

    nav_command_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .btn       (btn),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic exp_v;
        logic bad;
        int   xfers;

        reset     = 1'b1;
        btn       = '0;
        cmd_ready = 1'b1;
        do_reset();
        chk("rst_valid", cmd_valid, 0);
        chk("rst_code", cmd_code, 0);
        chk("rst_busy", busy, 0);

        // 3-cycle glitch is shorter than the debounce window
        btn[0] = 1'b1;
        step(); step(); step();
        btn[0] = 1'b0;
        bad = 1'b0;
        for (int e = 0; e < 15; e++) begin
            step();
            if (cmd_valid || busy) bad = 1'b1;
        end
        chk("glitch_quiet", bad, 0);

        // Held press: first command at edge 8, repeats from edge 28 every 8
        do_reset();
        cmd_ready = 1'b1;
        btn[2] = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            step();
            exp_v = (e == 8) || (e >= 28 && ((e - 28) % 8) == 0);
            chk($sformatf("hold_valid_e%0d", e), cmd_valid, exp_v);
            if (exp_v) chk($sformatf("hold_code_e%0d", e), cmd_code, 2);
        end
        btn[2] = 1'b0;
        bad = 1'b0;
        for (int e = 0; e < 20; e++) begin
            step();
            if (cmd_valid) bad = 1'b1;
        end
        chk("release_no_repeat", bad, 0);
        chk("release_busy", busy, 0);

        // All five at once drain round-robin from 0 with a bubble between
        do_reset();
        cmd_ready = 1'b1;
        btn = 5'b11111;
        for (int e = 1; e <= 17; e++) begin
            step();
            exp_v = (e >= 8 && e <= 16 && (e % 2) == 0);
            chk($sformatf("all_valid_e%0d", e), cmd_valid, exp_v);
            if (exp_v)
                chk($sformatf("all_code_e%0d", e), cmd_code, (e - 8) / 2);
        end
        btn = '0;
        bad = 1'b0;
        for (int e = 0; e < 20; e++) begin
            step();
            if (cmd_valid) bad = 1'b1;
        end
        chk("all_no_extra", bad, 0);
        chk("all_busy_idle", busy, 0);

        // Back-pressure: offer holds, re-press coalesces, single transfer
        do_reset();
        cmd_ready = 1'b0;
        btn[4] = 1'b1;
        for (int e = 0; e < 8; e++) step();
        chk("bp_valid", cmd_valid, 1);
        chk("bp_code", cmd_code, 4);
        chk("bp_busy", busy, 1);
        bad = 1'b0;
        for (int e = 0; e < 50; e++) begin
            step();
            if (!cmd_valid || cmd_code != 3'd4) bad = 1'b1;
        end
        btn[4] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            if (!cmd_valid || cmd_code != 3'd4) bad = 1'b1;
        end
        btn[4] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            if (!cmd_valid || cmd_code != 3'd4) bad = 1'b1;
        end
        btn[4] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            if (!cmd_valid || cmd_code != 3'd4) bad = 1'b1;
        end
        chk("bp_stable", bad, 0);
        cmd_ready = 1'b1;
        xfers = 0;
        for (int e = 0; e < 20; e++) begin
            if (cmd_valid && cmd_ready) xfers++;
            step();
        end
        chk("bp_xfers", xfers, 1);
        chk("bp_busy_end", busy, 0);

        // Reset during an offer, button still held afterwards
        do_reset();
        cmd_ready = 1'b0;
        btn[3] = 1'b1;
        for (int e = 0; e < 8; e++) step();
        chk("mid_valid", cmd_valid, 1);
        chk("mid_code", cmd_code, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_code", cmd_code, 0);
        for (int e = 1; e <= 9; e++) begin
            step();
            chk($sformatf("mid_re_valid_e%0d", e), cmd_valid, (e >= 8));
            if (e >= 8) chk($sformatf("mid_re_code_e%0d", e), cmd_code, 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
